// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  // Controller states: waiting for start, adding one bit per cycle, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell.
//   a, b : addend bits
//   d    : carry in
//   s    : sum bit
//   c    : carry out
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic d,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ d;
  assign c = (a & b) | (d & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, start/busy/done handshake.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : request, honoured only while idle
//   a, b, cin     : operands and carry-in, captured when start is accepted
//   busy          : high while an addition is in flight or its result is being signalled
//   done          : one-cycle pulse when sum/cout are updated
//   sum, cout     : registered result, held until the next completion
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic [WIDTH-1:0]   sum_sh_nxt;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               fa_s;
  logic               fa_c;

  // Per-bit sum and carry from the current LSBs.
  serial_adder_fa u_fa (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .d (carry),
    .s (fa_s),
    .c (fa_c)
  );

  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB; written as a wide shift so WIDTH=1 needs no special case.
  assign sum_sh_nxt = WIDTH'({fa_s, sum_sh} >> 1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        ADD: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          sum_sh <= sum_sh_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= sum_sh_nxt;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // 8-bit instance
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  // 3-bit instance
  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: an accepted request yields a+b+cin WIDTH cycles later,
  // then one more cycle of busy before idle.
  logic       m8_busy = 1'b0, m8_done = 1'b0, e8_cout = 1'b0;
  int         m8_left = 0;
  logic [8:0] m8_res  = '0;
  logic [7:0] e8_sum  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_busy = 1'b0; m8_done = 1'b0; m8_left = 0; e8_sum = '0; e8_cout = 1'b0;
    end else begin
      m8_done = 1'b0;
      if (!m8_busy) begin
        if (start8) begin
          m8_busy = 1'b1;
          m8_left = 8;
          m8_res  = 9'(a8) + 9'(b8) + 9'(cin8);
        end
      end else if (m8_left != 0) begin
        m8_left--;
        if (m8_left == 0) begin
          m8_done = 1'b1;
          {e8_cout, e8_sum} = m8_res;
        end
      end else begin
        m8_busy = 1'b0;
      end
    end
  end

  logic       m3_busy = 1'b0, m3_done = 1'b0, e3_cout = 1'b0;
  int         m3_left = 0;
  int         m3_acc  = 0;
  logic [3:0] m3_res  = '0;
  logic [2:0] e3_sum  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m3_busy = 1'b0; m3_done = 1'b0; m3_left = 0; e3_sum = '0; e3_cout = 1'b0;
    end else begin
      m3_done = 1'b0;
      if (!m3_busy) begin
        if (start3) begin
          m3_busy = 1'b1;
          m3_left = 3;
          m3_res  = 4'(a3) + 4'(b3) + 4'(cin3);
          m3_acc++;
        end
      end else if (m3_left != 0) begin
        m3_left--;
        if (m3_left == 0) begin
          m3_done = 1'b1;
          {e3_cout, e3_sum} = m3_res;
        end
      end else begin
        m3_busy = 1'b0;
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  int n_done3 = 0;
  int last3   = -1;
  always @(negedge clk) begin
    chk("busy8", 32'(busy8), 32'(m8_busy));
    chk("done8", 32'(done8), 32'(m8_done));
    chk("sum8",  32'(sum8),  32'(e8_sum));
    chk("cout8", 32'(cout8), 32'(e8_cout));
    chk("busy3", 32'(busy3), 32'(m3_busy));
    chk("done3", 32'(done3), 32'(m3_done));
    chk("sum3",  32'(sum3),  32'(e3_sum));
    chk("cout3", 32'(cout3), 32'(e3_cout));
    if (done3 === 1'b1) begin
      if (last3 >= 0) chk("spacing3", 32'(cyc - last3), 32'd5);
      last3 = cyc;
      n_done3++;
    end
  end

  // Runs one 8-bit addition; optionally pulses start again mid-operation.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                    input logic [7:0] exp_s, input logic exp_c, input bit glitch);
    int lat, ndone;
    logic [7:0] got_s;
    logic got_c;
    lat = 0; ndone = 0; got_s = 'x; got_c = 1'bx;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (glitch && k == 2) begin a8 = 8'h10; b8 = 8'h10; start8 = 1'b1; end
      if (glitch && k == 3) start8 = 1'b0;
      if (done8 === 1'b1) begin
        ndone++;
        if (ndone == 1) begin lat = k; got_s = sum8; got_c = cout8; end
      end
    end
    chk("latency",  32'(lat),   32'd8);
    chk("n_done",   32'(ndone), 32'd1);
    chk("sum_lit",  32'(got_s), 32'(exp_s));
    chk("cout_lit", 32'(got_c), 32'(exp_c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int nd;
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum",  32'(sum8),  32'h00);
    chk("rst_cout", 32'(cout8), 32'd0);
    start8 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op(8'h21, 8'h42, 1'b0, 8'h63, 1'b0, 1'b1);

    // Abort after four bits: no result may follow.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_sum",  32'(sum8),  32'h00);
    #1 rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0);

    // Exhaustive 3-bit run with start held high.
    @(negedge clk);
    start3 = 1'b1;
    for (int k = 0; k < 128; k++) begin
      int t;
      logic [6:0] v;
      v = 7'(k);
      {a3, b3, cin3} = v;
      t = 0;
      while (m3_acc < k + 1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("accept3", 32'(m3_acc), 32'(k + 1));
    end
    start3 = 1'b0;
    repeat (10) @(negedge clk);
    chk("dones3",    32'(n_done3), 32'd128);
    chk("last_sum3", 32'(sum3),    32'd7);
    chk("last_cout3", 32'(cout3),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle, bit-serial WIDTH-bit adder built around the team's one-bit FullAdder cell (A, B, D carry-in -> S sum, C carry-out).
- Adds one bit per clock, LSB first, with the carry held in a flip-flop between bits.
- Sits directly downstream of operand sources (switches/registers) and feeds the display/result stage.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high in ADD and DONE states
- done  output  1  one-cycle pulse; sum/cout valid from this cycle
- sum  output  WIDTH  registered result; held until next completion
- cout  output  1  registered final carry; held until next completion

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - An in-flight addition is abandoned; no done pulse follows.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at edge t0: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; go to ADD.
  - start=0: remain in IDLE.
- ADD, at each edge:
  - FullAdder inputs are a_sh[0], b_sh[0], carry.
  - S is shifted into the MSB of the sum shift register (shift right).
  - carry<=C; a_sh and b_sh shift right; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1 (edge t0+WIDTH): sum<=final shifted value, cout<=C, go to DONE.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: done high in the cycle following edge t0+WIDTH, i.e. WIDTH cycles after the accepting edge. Back-to-back throughput is one result per WIDTH+2 cycles.
- start is ignored while busy=1 (ADD or DONE). Operands changing during ADD have no effect.
- start held high continuously: a new operation is accepted on the first edge back in IDLE.
- sum and cout change only on the edge entering DONE (or on reset); they are stable at all other times.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- cnt width is $clog2(WIDTH+1); no wrap occurs because the ADD exit happens at WIDTH-1.
- WIDTH=1: a single ADD cycle, then DONE.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package serial_adder_pkg: state_t enum (IDLE, ADD, DONE) and DEFAULT_WIDTH=8.
- One sub-module, the existing FullAdder cell, instantiated once for the per-bit sum/carry.
- The FSM, counter and shift registers stay in serial_adder.

Test Plan:
- Reset with start=1 and random operands -> busy=0, done=0, sum=8'h00, cout=0; no activity until rst_n rises.
- a=8'h05, b=8'h03, cin=0, start pulsed at edge t0 -> done high exactly after edge t0+8, sum=8'h08, cout=0; done low on the next cycle.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start pulsed again at cycle 3 of an operation with a=8'h10, b=8'h10 -> ignored; the first result is returned, and a single done pulse occurs.
- rst_n low for one cycle after 4 bits processed -> busy=0, sum=0, no done; a fresh a=8'h7F, b=8'h01 then yields sum=8'h80, cout=0.
- WIDTH=3 exhaustive: all 128 (a,b,cin) combinations, start held high -> each {cout,sum} equals a+b+cin, done spacing exactly 5 cycles.
